// File: rtl/branch_pkg.sv
// Shared branch condition codes and predictor counter helpers.
// Imported by the condition evaluator and the prediction unit.
package branch_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_JUMP = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;
    localparam logic [2:0] BR_BLEZ = 3'b110;
    localparam logic [2:0] BR_BGTZ = 3'b111;

    // Weakly not-taken: MSB clear, every lower bit set.
    function automatic int cnt_init(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch decision for the 3-bit condition set.
// Ports: branchop, zero, neg in; taken out.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] branchop,
    input  logic       zero,
    input  logic       neg,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (branchop)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_JUMP: taken = 1'b1;
            BR_BLTZ: taken = neg;
            BR_BGEZ: taken = ~neg;
            BR_BLEZ: taken = neg | zero;
            BR_BGTZ: taken = ~neg & ~zero;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// PC-indexed saturating-counter predictor with EX-stage resolution.
// Ports: pred_* lookup from IF, res_* resolution from EX, stat_* counters.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_pc,
    output logic              pred_out_valid,
    output logic              pred_out_taken,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic [2:0]        res_branchop,
    input  logic              res_zero,
    input  logic              res_neg,
    input  logic              res_pred_taken,
    output logic              res_out_valid,
    output logic              res_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int N = 1 << IDX_W;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(cnt_init(CNT_W));
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [CNT_W-1:0] tbl [N];
    logic [IDX_W-1:0] pidx;
    logic [IDX_W-1:0] ridx;
    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] nxt;
    logic             taken;
    logic             is_br;
    logic             miss;
    logic             unused_pc;

    assign pidx  = pred_pc[IDX_W+1:2];
    assign ridx  = res_pc[IDX_W+1:2];
    assign is_br = (res_branchop != BR_NONE);
    assign miss  = taken ^ res_pred_taken;

    // Word-aligned PCs: low bits and high bits alias into the table.
    assign unused_pc = ^{pred_pc[ADDR_W-1:IDX_W+2], pred_pc[1:0],
                         res_pc[ADDR_W-1:IDX_W+2], res_pc[1:0]};

    branch_cond_eval u_cond (
        .branchop (res_branchop),
        .zero     (res_zero),
        .neg      (res_neg),
        .taken    (taken)
    );

    always_comb begin
        cur = tbl[ridx];
        nxt = cur;
        if (taken && cur != CNT_MAX)
            nxt = cur + 1'b1;
        else if (!taken && cur != '0)
            nxt = cur - 1'b1;
    end

    // Lookup reads the array before this edge's write: read-before-write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++)
                tbl[i] <= CNT_INIT;
        end else if (res_valid && is_br) begin
            tbl[ridx] <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_out_valid <= 1'b0;
            pred_out_taken <= 1'b0;
        end else begin
            pred_out_valid <= pred_valid;
            if (pred_valid)
                pred_out_taken <= tbl[pidx][CNT_W-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_out_valid <= 1'b0;
            res_taken     <= 1'b0;
            mispredict    <= 1'b0;
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            res_out_valid <= res_valid;
            mispredict    <= res_valid & miss;
            if (res_valid)
                res_taken <= taken;
            if (res_valid && is_br && stat_branches != STAT_MAX)
                stat_branches <= stat_branches + 1'b1;
            if (res_valid && miss && stat_mispred != STAT_MAX)
                stat_mispred <= stat_mispred + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized bench for branch_predict_unit against an array model.
// Drives at negedge, checks #1 after posedge.
module tb_branch_predict_unit;

    localparam int SMAX  = 15;
    localparam int CMAX  = 3;
    localparam int CINIT = 1;
    localparam int NENT  = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_out_valid;
    logic        pred_out_taken;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic [2:0]  res_branchop = '0;
    logic        res_zero = 1'b0;
    logic        res_neg = 1'b0;
    logic        res_pred_taken = 1'b0;
    logic        res_out_valid;
    logic        res_taken;
    logic        mispredict;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispred;

    int n_chk = 0;
    int n_err = 0;

    int ctr [NENT];
    int m_sb, m_sm;
    bit e_pov, e_pt, e_rov, e_rt, e_mp;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .ADDR_W (32),
        .IDX_W  (6),
        .CNT_W  (2),
        .STAT_W (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_out_valid (pred_out_valid),
        .pred_out_taken (pred_out_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_branchop   (res_branchop),
        .res_zero       (res_zero),
        .res_neg        (res_neg),
        .res_pred_taken (res_pred_taken),
        .res_out_valid  (res_out_valid),
        .res_taken      (res_taken),
        .mispredict     (mispredict),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic bit cond(input int op, input bit z, input bit n);
        case (op)
            0: return 1'b0;
            1: return z;
            2: return !z;
            3: return 1'b1;
            4: return n;
            5: return !n;
            6: return n || z;
            default: return !n && !z;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) ctr[i] = CINIT;
        m_sb = 0; m_sm = 0;
        e_pov = 0; e_pt = 0; e_rov = 0; e_rt = 0; e_mp = 0;
    endtask

    task automatic check_all();
        chk("pred_out_valid", 32'(pred_out_valid), 32'(e_pov));
        chk("pred_out_taken", 32'(pred_out_taken), 32'(e_pt));
        chk("res_out_valid", 32'(res_out_valid), 32'(e_rov));
        chk("res_taken", 32'(res_taken), 32'(e_rt));
        chk("mispredict", 32'(mispredict), 32'(e_mp));
        chk("stat_branches", 32'(stat_branches), 32'(m_sb));
        chk("stat_mispred", 32'(stat_mispred), 32'(m_sm));
    endtask

    task automatic step(input bit pv, input logic [31:0] ppc,
                        input bit rv, input logic [31:0] rpc,
                        input int op, input bit z, input bit n,
                        input bit rpt);
        bit t;
        int k;
        @(negedge clk);
        pred_valid = pv; pred_pc = ppc;
        res_valid = rv; res_pc = rpc; res_branchop = 3'(op);
        res_zero = z; res_neg = n; res_pred_taken = rpt;
        e_pov = pv;
        if (pv) e_pt = ctr[idx(ppc)] > CMAX / 2;
        e_rov = rv;
        e_mp = 0;
        if (rv) begin
            t = cond(op, z, n);
            e_rt = t;
            e_mp = (t != rpt);
            if (op != 0) begin
                k = idx(rpc);
                ctr[k] = t ? ((ctr[k] < CMAX) ? ctr[k] + 1 : CMAX)
                           : ((ctr[k] > 0) ? ctr[k] - 1 : 0);
                if (m_sb < SMAX) m_sb++;
            end
            if (e_mp && m_sm < SMAX) m_sm++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // First lookup after reset is not-taken.
        step(1, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("first_pred", 32'(pred_out_taken), 32'd0);

        // Collision: pre-update value this cycle, new value next.
        step(1, 32'h40, 1, 32'h40, 1, 1, 0, 0);
        // Alias 0x140 shares the 0x40 entry.
        step(0, 0, 1, 32'h140, 1, 1, 0, 0);
        step(1, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("beq_trained", 32'(pred_out_taken), 32'd1);
        chk("beq_mispred", 32'(stat_mispred), 32'd2);

        // Saturation at top and bottom.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h40, 3, 0, 0, 1);
        step(1, 32'h140, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h80, 1, 0, 0, 0);
        step(1, 32'h80, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h80, 1, 1, 0, 0);
        step(1, 32'h80, 0, 0, 0, 0, 0, 0);

        // All ops against each zero/neg pattern.
        for (int op = 0; op < 8; op++)
            for (int zn = 0; zn < 3; zn++)
                step(1, 32'h100, 1, 32'h100, op, zn[1], zn[0],
                     1'($urandom_range(0, 1)));
        idle();

        // Random traffic over a few colliding PCs; stats saturate.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 7)) << 6,
                 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 7)) << 6,
                 int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));

        // Async reset in the middle of a resolution burst.
        step(0, 0, 1, 32'h40, 3, 0, 0, 0);
        step(1, 32'h40, 1, 32'h40, 3, 0, 0, 0);
        @(negedge clk);
        res_valid = 1'b1; pred_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        pred_valid = 1'b0; res_valid = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < NENT; i++)
            step(1, 32'(i) << 2, 0, 0, 0, 0, 0, 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
